// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - unified memory port handshake between control FSM and memory
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multi-cycle RV32I core
module multicycle_ctrl (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [6:0]               i_opcode,
  input  logic [2:0]               i_funct3,
  input  logic                     i_zero,
  multicycle_ctrl_if.master        mem,
  output logic                     o_ir_write,
  output logic                     o_pc_write,
  output logic [1:0]               o_alu_src_a,
  output logic [1:0]               o_alu_src_b,
  output logic [1:0]               o_alu_op,
  output logic [1:0]               o_result_src,
  output logic                     o_reg_write,
  output logic                     o_instr_done,
  output logic                     o_illegal,
  output logic [3:0]               o_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_result_src;
  logic       w_reg_write;
  logic       w_instr_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_result_src = 2'b00;
    w_reg_write  = 1'b0;
    w_instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_ir_write   = mem.mem_ready;
        w_pc_write   = mem.mem_ready;
        if (mem.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures oldPC+imm here so BRANCH/JAL find their target ready
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        case (i_opcode)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXEC_R;
          7'b0010011:             w_next = S_EXEC_I;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b10;
        w_next      = (i_opcode == 7'b0000011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (mem.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req    = 1'b1;
        w_mem_we     = 1'b1;
        w_iord       = 1'b1;
        w_instr_done = mem.mem_ready;
        if (mem.mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXEC_I: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b10;
        w_alu_op    = 2'b11;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a  = 2'b10;
        w_alu_op     = 2'b01;
        w_instr_done = 1'b1;
        w_pc_write   = (i_funct3 == 3'b000) ? i_zero :
                       (i_funct3 == 3'b001) ? ~i_zero : 1'b0;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target in ALUOut while ALUOut reloads with oldPC+4 for the link
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_pc_write  = 1'b1;
        w_next      = S_ALUWB;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every output low, dropping any in-flight memory request
  assign mem.mem_req   = w_mem_req & ~i_rst;
  assign mem.mem_we    = w_mem_we & ~i_rst;
  assign mem.iord      = w_iord & ~i_rst;
  assign o_ir_write    = w_ir_write & ~i_rst;
  assign o_pc_write    = w_pc_write & ~i_rst;
  assign o_alu_src_a   = i_rst ? 2'b00 : w_alu_src_a;
  assign o_alu_src_b   = i_rst ? 2'b00 : w_alu_src_b;
  assign o_alu_op      = i_rst ? 2'b00 : w_alu_op;
  assign o_result_src  = i_rst ? 2'b00 : w_result_src;
  assign o_reg_write   = w_reg_write & ~i_rst;
  assign o_instr_done  = w_instr_done & ~i_rst;
  assign o_illegal     = r_illegal & ~i_rst;
  assign o_state       = i_rst ? 4'd0 : r_state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RISC-V core. It sequences one shared ALU, one unified memory port and the register file over several cycles per instruction. Each cycle it drives the mux selects, write strobes and the 2-bit ALUOp that the ALU control decoder expands into the ALU operation. It covers RV32I R-type, I-type ALU, LW, SW, BEQ/BNE and JAL. Every other opcode traps.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction register [6:0].
- funct3  in  3  instruction register [14:12]; used only for branch sense.
- zero  in  1  ALU zero flag, combinational from the current ALU operation.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and oldPC from the memory data.
- pc_write  out  1  load the PC from the result bus.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  ALU control class: 00 = add, 01 = subtract, 10 = R-type, 11 = I-type.
- result_src  out  2  result bus select: 00 = ALUOut, 01 = memory data register, 10 = ALU result.
- reg_write  out  1  register file write of the result bus into rd.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  sticky flag, set when the core enters TRAP.
- state  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11.
- Unlisted outputs are 0 in every state. Selects default to 00.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - Holds in FETCH while mem_ready=0. Moves to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00, so ALUOut = oldPC+imm (branch/jump target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=10, alu_op=00. Goes to MEMRD for a load, MEMWR for a store.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next state FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Holds until mem_ready=1. In the cycle with mem_ready=1, instr_done=1; next state FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10. Next state ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=10, alu_op=11. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next state FETCH.
- BRANCH:
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero when funct3=000 (BEQ); pc_write = ~zero when funct3=001 (BNE); pc_write=0 for any other funct3.
  - instr_done=1. Next state FETCH.
- JAL:
  - Drives alu_src_a=01, alu_src_b=01, alu_op=00, result_src=00, pc_write=1.
  - The PC takes the target already in ALUOut, while ALUOut is loaded with oldPC+4.
  - Next state ALUWB, which writes the link value into rd.
- TRAP: all strobes 0, illegal=1. Stays in TRAP until rst.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Outputs are Moore decodes of the state. The exceptions are combinational on the current-cycle inputs: ir_write and pc_write in FETCH (on mem_ready), instr_done in MEMWR (on mem_ready), and pc_write in BRANCH (on zero and funct3).
- Reset:
  - While rst=1, every output is 0, including mem_req and all selects.
  - On the edge with rst=1, state becomes FETCH and illegal clears.
  - rst takes priority in every state, including mid-wait in MEMRD or MEMWR. The pending request is dropped and no write strobe is issued.
- Latency with zero memory wait (cycles from FETCH entry to instr_done, inclusive):
  - BRANCH: 3
  - R-type, I-type, SW: 4
  - JAL: 4
  - LW: 5
- Each mem_ready=0 cycle in a memory state adds exactly one cycle to the instruction.
- mem_req stays high continuously until the mem_ready handshake completes. It drops in the following cycle unless the next state also requests memory (for example MEMWR -> FETCH).

## Test plan
- Reset: hold rst=1 for 3 cycles with mem_ready=1 -> all outputs 0 throughout; first cycle after release shows state=0, mem_req=1, iord=0.
- R-type (opcode 0110011), mem_ready=1 -> state sequence 0,1,6,8; alu_op=10 in EXEC_R; reg_write and instr_done high only in ALUWB.
- LW with mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4 (7 cycles); mem_req held for all 3 MEMRD cycles; reg_write with result_src=01 in MEMWB.
- BEQ with zero=1, then BNE with zero=1 -> pc_write=1 for the BEQ and pc_write=0 for the BNE in BRANCH; both take 3 cycles.
- JAL -> sequence 0,1,10,8; pc_write=1 with result_src=00 in JAL; reg_write in ALUWB.
- Illegal opcode 1111111 -> TRAP, illegal=1 held for 10 cycles; then rst pulse -> illegal=0, state=0. Also: rst asserted mid-MEMWR -> mem_we and instr_done never pulse; FETCH follows.
